// File: rtl/wm_pkg.sv
// Shared types and helpers for the washing-machine cycle controller.
// State encodings are visible on the phase output.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RINSE = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } wm_state_e;

    // Quick mode halves a duration but never drops it below one cycle.
    function automatic int unsigned dur_sel(
        input int unsigned cyc,
        input logic        quick
    );
        int unsigned half;
        half = cyc >> 1;
        if (!quick) return cyc;
        return (half == 32'd0) ? 32'd1 : half;
    endfunction

endpackage

// File: rtl/wm_btn_edge.sv
// Single-bit rising-edge detector for a synchronous button level.
// A level held high yields exactly one rise.
module wm_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic btn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_q <= 1'b0;
        else       btn_q <= btn;
    end

    assign rise = btn & ~btn_q;

endmodule

// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: fill, wash, drain, rinse/drain
// passes and spin, with a freezing pause toggle and a done pulse.
module wm_cycle_ctrl
    import wm_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned FILL_CYC  = 4,
    parameter int unsigned WASH_CYC  = 8,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned RINSE_CYC = 5,
    parameter int unsigned SPIN_CYC  = 6,
    parameter int unsigned MAX_RINSE = 3,
    parameter int unsigned RS_W      = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_button,
    input  logic            pause_button,
    input  logic            quick_mode,
    input  logic [RS_W-1:0] rinse_sel,
    output logic            water_in,
    output logic            drain_valve,
    output logic            motor_on,
    output logic            motor_fast,
    output logic            busy,
    output logic            paused,
    output logic [2:0]      phase,
    output logic            out
);

    typedef logic [CNT_W-1:0] cnt_t;

    // Timer preloads (duration - 1), resolved at elaboration.
    localparam cnt_t FILL_N  = cnt_t'(dur_sel(FILL_CYC, 1'b0) - 1);
    localparam cnt_t FILL_Q  = cnt_t'(dur_sel(FILL_CYC, 1'b1) - 1);
    localparam cnt_t WASH_N  = cnt_t'(dur_sel(WASH_CYC, 1'b0) - 1);
    localparam cnt_t WASH_Q  = cnt_t'(dur_sel(WASH_CYC, 1'b1) - 1);
    localparam cnt_t DRAIN_N = cnt_t'(dur_sel(DRAIN_CYC, 1'b0) - 1);
    localparam cnt_t DRAIN_Q = cnt_t'(dur_sel(DRAIN_CYC, 1'b1) - 1);
    localparam cnt_t RINSE_N = cnt_t'(dur_sel(RINSE_CYC, 1'b0) - 1);
    localparam cnt_t RINSE_Q = cnt_t'(dur_sel(RINSE_CYC, 1'b1) - 1);
    localparam cnt_t SPIN_N  = cnt_t'(dur_sel(SPIN_CYC, 1'b0) - 1);
    localparam cnt_t SPIN_Q  = cnt_t'(dur_sel(SPIN_CYC, 1'b1) - 1);

    localparam logic [RS_W-1:0] RS_MAX = RS_W'(MAX_RINSE);

    function automatic cnt_t load_of(input wm_state_e s, input logic q);
        case (s)
            ST_FILL:  return q ? FILL_Q  : FILL_N;
            ST_WASH:  return q ? WASH_Q  : WASH_N;
            ST_DRAIN: return q ? DRAIN_Q : DRAIN_N;
            ST_RINSE: return q ? RINSE_Q : RINSE_N;
            ST_SPIN:  return q ? SPIN_Q  : SPIN_N;
            default:  return '0;
        endcase
    endfunction

    logic start_rise;
    logic pause_rise;

    wm_btn_edge u_start_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (start_button),
        .rise  (start_rise)
    );

    wm_btn_edge u_pause_edge (
        .clk   (clk),
        .reset (reset),
        .btn   (pause_button),
        .rise  (pause_rise)
    );

    wm_state_e       state, state_d, seq_nxt;
    cnt_t            timer, timer_d;
    logic            paused_d;
    logic            quick_q, quick_d;
    logic [RS_W-1:0] rinse_left, rinse_d, rinse_clamp;

    assign rinse_clamp = (rinse_sel > RS_MAX) ? RS_MAX : rinse_sel;

    always_comb begin
        seq_nxt = ST_IDLE;
        case (state)
            ST_FILL:  seq_nxt = ST_WASH;
            ST_WASH:  seq_nxt = ST_DRAIN;
            ST_DRAIN: seq_nxt = (rinse_left != '0) ? ST_RINSE : ST_SPIN;
            ST_RINSE: seq_nxt = ST_DRAIN;
            ST_SPIN:  seq_nxt = ST_DONE;
            default:  seq_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d  = state;
        timer_d  = timer;
        paused_d = paused;
        quick_d  = quick_q;
        rinse_d  = rinse_left;
        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_FILL;
                    quick_d = quick_mode;
                    rinse_d = rinse_clamp;
                    timer_d = load_of(ST_FILL, quick_mode);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                if (pause_rise) paused_d = ~paused;
                // Freezing keys off the registered flag, so a pause
                // costs exactly as many cycles as the flag is high.
                if (!paused) begin
                    if (timer == '0) begin
                        state_d = seq_nxt;
                        timer_d = load_of(seq_nxt, quick_q);
                        if (state == ST_RINSE) rinse_d = rinse_left - 1'b1;
                        if (seq_nxt == ST_DONE) paused_d = 1'b0;
                    end else begin
                        timer_d = timer - 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            paused      <= 1'b0;
            quick_q     <= 1'b0;
            rinse_left  <= '0;
            water_in    <= 1'b0;
            drain_valve <= 1'b0;
            motor_on    <= 1'b0;
            motor_fast  <= 1'b0;
            busy        <= 1'b0;
            phase       <= 3'd0;
            out         <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            paused      <= paused_d;
            quick_q     <= quick_d;
            rinse_left  <= rinse_d;
            water_in    <= !paused_d &&
                           (state_d == ST_FILL || state_d == ST_RINSE);
            drain_valve <= !paused_d &&
                           (state_d == ST_DRAIN || state_d == ST_SPIN);
            motor_on    <= !paused_d &&
                           (state_d == ST_WASH || state_d == ST_RINSE ||
                            state_d == ST_SPIN);
            motor_fast  <= !paused_d && (state_d == ST_SPIN);
            busy        <= (state_d != ST_IDLE);
            phase       <= state_d;
            out         <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl: per-cycle phase/output traces
// built from hand-listed durations, plus reset and edge cases.
module tb_wm_cycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_button;
    logic       pause_button;
    logic       quick_mode;
    logic [1:0] rinse_sel;
    logic       water_in;
    logic       drain_valve;
    logic       motor_on;
    logic       motor_fast;
    logic       busy;
    logic       paused;
    logic [2:0] phase;
    logic       out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wm_cycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start_button (start_button),
        .pause_button (pause_button),
        .quick_mode   (quick_mode),
        .rinse_sel    (rinse_sel),
        .water_in     (water_in),
        .drain_valve  (drain_valve),
        .motor_on     (motor_on),
        .motor_fast   (motor_fast),
        .busy         (busy),
        .paused       (paused),
        .phase        (phase),
        .out          (out)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-listed durations: normal 4,8,3,5,3,6; quick 2,4,1,2,1,3.
    function automatic int dur(input int p, input bit q);
        case (p)
            1:       return q ? 2 : 4;
            2:       return q ? 4 : 8;
            3:       return q ? 1 : 3;
            4:       return q ? 2 : 5;
            5:       return q ? 3 : 6;
            default: return 1;
        endcase
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "/phase"}, int'(phase), 0);
        chk({tag, "/busy"}, int'(busy), 0);
        chk({tag, "/out"}, int'(out), 0);
        chk({tag, "/paused"}, int'(paused), 0);
        chk({tag, "/motor"}, int'(motor_on), 0);
        chk({tag, "/fast"}, int'(motor_fast), 0);
        chk({tag, "/water"}, int'(water_in), 0);
        chk({tag, "/drain"}, int'(drain_valve), 0);
    endtask

    task automatic run_prog(
        input string tag,
        input int    rinse,
        input bit    quick,
        input int    pz_at,
        input int    pz_len,
        input int    hold,
        input int    restart_at,
        input bit    pz0,
        input bit    toggle_q,
        input int    exp_done
    );
        int ph[$];
        bit pz[$];
        int lst[$];
        int first_out = -1;
        int n_out = 0;
        int busy_fall = -1;
        int ep;
        bit epz;
        lst = {1, 2, 3};
        repeat (rinse) lst = {lst, 4, 3};
        lst = {lst, 5, 6};
        foreach (lst[i]) begin
            repeat (dur(lst[i], quick)) begin
                ph.push_back(lst[i]);
                pz.push_back(1'b0);
            end
        end
        repeat (15) begin
            ph.push_back(0);
            pz.push_back(1'b0);
        end
        for (int j = 0; j < pz_len; j++) begin
            ph.insert(pz_at, ph[pz_at]);
            pz.insert(pz_at, 1'b1);
        end

        start_button = 1'b1;
        pause_button = pz0;
        rinse_sel    = 2'(rinse);
        quick_mode   = quick;
        tick();
        for (int c = 1; c <= ph.size(); c++) begin
            ep  = ph[c-1];
            epz = pz[c-1];
            chk($sformatf("%s/phase@%0d", tag, c), int'(phase), ep);
            chk($sformatf("%s/paused@%0d", tag, c), int'(paused), int'(epz));
            chk($sformatf("%s/busy@%0d", tag, c), int'(busy), int'(ep != 0));
            chk($sformatf("%s/out@%0d", tag, c), int'(out), int'(ep == 6));
            chk($sformatf("%s/motor@%0d", tag, c), int'(motor_on),
                int'(!epz && (ep == 2 || ep == 4 || ep == 5)));
            chk($sformatf("%s/fast@%0d", tag, c), int'(motor_fast),
                int'(!epz && ep == 5));
            chk($sformatf("%s/water@%0d", tag, c), int'(water_in),
                int'(!epz && (ep == 1 || ep == 4)));
            chk($sformatf("%s/drain@%0d", tag, c), int'(drain_valve),
                int'(!epz && (ep == 3 || ep == 5)));
            if (out && first_out < 0) first_out = c;
            if (out) n_out++;
            if (busy_fall < 0 && first_out >= 0 && !busy) busy_fall = c;
            start_button = (c < hold) || (c == restart_at);
            pause_button = (pz_len > 0) &&
                           ((c == pz_at) || (c == pz_at + pz_len));
            if (toggle_q) quick_mode = ~quick_mode;
            tick();
        end
        chk({tag, "/out_cycle"}, first_out, exp_done);
        chk({tag, "/out_count"}, n_out, 1);
        chk({tag, "/busy_fall"}, busy_fall, exp_done + 1);
        start_button = 1'b0;
        pause_button = 1'b0;
        quick_mode   = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        start_button = 1'b0;
        pause_button = 1'b0;
        quick_mode   = 1'b0;
        rinse_sel    = 2'd0;
        #1;
        chk_idle_outs("reset");
        tick();
        reset = 1'b0;
        tick();
        chk_idle_outs("post_reset");

        // Pause rise while idle is ignored.
        pause_button = 1'b1;
        tick();
        chk_idle_outs("idle_pause");
        pause_button = 1'b0;
        tick();

        run_prog("rinse1", 1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0, 30);
        run_prog("rinse0", 0, 1'b0, 0, 0, 1, 10, 1'b0, 1'b0, 22);
        run_prog("rinse3", 3, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0, 46);
        run_prog("quick", 1, 1'b1, 0, 0, 1, 0, 1'b0, 1'b1, 14);
        run_prog("pause", 1, 1'b0, 7, 20, 1, 0, 1'b0, 1'b0, 50);
        run_prog("hold40", 1, 1'b0, 0, 0, 40, 0, 1'b0, 1'b0, 30);
        run_prog("start_pause", 1, 1'b0, 0, 0, 1, 0, 1'b1, 1'b0, 30);

        // Asynchronous reset in the middle of a rinse pass.
        start_button = 1'b1;
        rinse_sel    = 2'd1;
        tick();
        start_button = 1'b0;
        repeat (16) tick();
        chk("rst_mid/pre_phase", int'(phase), 4);
        #2 reset = 1'b1;
        #1;
        chk_idle_outs("rst_mid/async");
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("rst_mid/out@%0d", i), int'(out), 0);
            chk($sformatf("rst_mid/phase@%0d", i), int'(phase), 0);
        end
        run_prog("after_rst", 1, 1'b0, 0, 0, 1, 0, 1'b0, 1'b0, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
